// File: rtl/ic_slv_sched.sv
// Per-slave address-channel scheduler: round-robin grant held until the slave
// accepts the address, with an outstanding-transaction lock to a single owner.
`timescale 1ns/1ps
module ic_slv_sched #(
   parameter int MSTRS     = 4,
   parameter int MSTR_BITS = 2,
   parameter int MAX_OUTST = 4,
   parameter int CNT_BITS  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [MSTRS-1:0]     m_req,
   input  logic                 s_aready,
   input  logic                 s_done,
   output logic [MSTRS-1:0]     grant,
   output logic                 grant_valid,
   output logic [MSTR_BITS-1:0] grant_num,
   output logic [MSTR_BITS-1:0] owner,
   output logic [CNT_BITS-1:0]  outst,
   output logic                 err
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t               state;
   logic [MSTR_BITS-1:0] last;
   logic                 hs;
   logic [MSTRS-1:0]     owner_mask;
   logic [MSTRS-1:0]     elig;
   logic                 can_grant;
   logic [MSTR_BITS-1:0] pick;

   // First set bit of elig scanning upward from last_i+1, wrapping modulo MSTRS.
   function automatic logic [MSTR_BITS-1:0] rr_pick(
      input logic [MSTRS-1:0]     elig_i,
      input logic [MSTR_BITS-1:0] last_i
   );
      logic [MSTRS-1:0] rot;
      logic             found;
      int               sh;
      sh      = (int'(last_i) + 1) % MSTRS;
      rot     = MSTRS'({elig_i, elig_i} >> sh);
      found   = 1'b0;
      rr_pick = last_i;
      for (int k = 0; k < MSTRS; k++) begin
         if (!found && rot[0]) begin
            rr_pick = MSTR_BITS'((sh + k) % MSTRS);
            found   = 1'b1;
         end
         rot = rot >> 1;
      end
   endfunction

   function automatic logic [MSTRS-1:0] one_hot(input logic [MSTR_BITS-1:0] idx);
      one_hot = MSTRS'(1) << idx;
   endfunction

   // Saturating at both ends; neither bound is reachable in legal operation.
   function automatic logic [CNT_BITS-1:0] cnt_next(
      input logic [CNT_BITS-1:0] cnt,
      input logic                inc,
      input logic                dec
   );
      cnt_next = cnt;
      if (inc && !dec && cnt != {CNT_BITS{1'b1}})
         cnt_next = cnt + CNT_BITS'(1);
      else if (dec && !inc && cnt != '0)
         cnt_next = cnt - CNT_BITS'(1);
   endfunction

   assign hs = grant_valid & s_aready;

   always_comb begin
      owner_mask = one_hot(owner);
      elig       = (outst == '0) ? m_req : (m_req & owner_mask);
      can_grant  = (|elig) && (outst < CNT_BITS'(MAX_OUTST));
      pick       = rr_pick(elig, last);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_num   <= '0;
         owner       <= '0;
         outst       <= '0;
         err         <= 1'b0;
         last        <= MSTR_BITS'(MSTRS - 1);
      end else begin
         outst <= cnt_next(outst, hs, s_done);
         if (s_done && !hs && outst == '0)
            err <= 1'b1;

         case (state)
            IDLE: begin
               if (can_grant) begin
                  state       <= HOLD;
                  grant       <= one_hot(pick);
                  grant_num   <= pick;
                  grant_valid <= 1'b1;
                  last        <= pick;
               end
            end
            HOLD: begin
               // Request changes are ignored here: AVALID may not drop before AREADY.
               if (hs) begin
                  state       <= IDLE;
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  owner       <= grant_num;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ic_slv_sched.sv
// Self-checking bench for ic_slv_sched: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ic_slv_sched;

   localparam int MSTRS = 4;
   localparam int MAXO  = 4;

   logic       clk;
   logic       reset;
   logic [3:0] m_req;
   logic       s_aready;
   logic       s_done;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_num;
   logic [1:0] owner;
   logic [2:0] outst;
   logic       err;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int md_gv, md_gidx, md_outst, md_owner, md_last, md_err;

   ic_slv_sched #(.MSTRS(4), .MSTR_BITS(2), .MAX_OUTST(4), .CNT_BITS(3)) dut (
      .clk(clk), .reset(reset), .m_req(m_req), .s_aready(s_aready), .s_done(s_done),
      .grant(grant), .grant_valid(grant_valid), .grant_num(grant_num),
      .owner(owner), .outst(outst), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_step();
      int         won;
      int         c;
      logic [3:0] t;
      logic       hs;
      if (reset == 1'b0) begin
         md_gv = 0; md_gidx = 0; md_outst = 0; md_owner = 0;
         md_last = MSTRS - 1; md_err = 0;
         return;
      end
      hs  = (md_gv != 0) && s_aready;
      won = -1;
      if (md_gv == 0 && md_outst < MAXO) begin
         for (int k = 1; k <= MSTRS; k++) begin
            c = (md_last + k) % MSTRS;
            t = m_req >> c;
            if (won < 0 && t[0] && (md_outst == 0 || c == md_owner)) won = c;
         end
      end
      if (hs && !s_done) md_outst++;
      else if (!hs && s_done) begin
         if (md_outst > 0) md_outst--;
         else md_err = 1;
      end
      if (hs) begin
         md_gv    = 0;
         md_owner = md_gidx;
      end
      if (won >= 0) begin
         md_gv = 1; md_gidx = won; md_last = won;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; m_req = '0; s_aready = 1'b0; s_done = 1'b0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; m_req = 4'b1111; s_aready = 1'b1; s_done = 1'b1;
      tick();
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gv: got %0h want 0", grant_valid); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %0h want 0", grant); end
      total++; if (grant_num !== 2'd0) begin bad++; $display("FAIL reset_gnum: got %0h want 0", grant_num); end
      total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner: got %0h want 0", owner); end
      total++; if (outst !== 3'd0) begin bad++; $display("FAIL reset_outst: got %0h want 0", outst); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0h want 0", err); end
      m_req = '0; s_aready = 1'b0; s_done = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      m_req = 4'b0100; s_aready = 1'b1;
      tick();
      total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL single_gv: got %0h want 1", grant_valid); end
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %0h want 4", grant); end
      total++; if (grant_num !== 2'd2) begin bad++; $display("FAIL single_gnum: got %0h want 2", grant_num); end
      m_req = '0;
      tick();
      total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL single_gv_drop: got %0h want 0", grant_valid); end
      total++; if (outst !== 3'd1) begin bad++; $display("FAIL single_outst: got %0h want 1", outst); end
      total++; if (owner !== 2'd2) begin bad++; $display("FAIL single_owner: got %0h want 2", owner); end
      s_done = 1'b1; tick(); s_done = 1'b0;
      total++; if (outst !== 3'd0) begin bad++; $display("FAIL single_done: got %0h want 0", outst); end
   endtask

   task automatic test_round_robin();
      logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      m_req = 4'b1111; s_aready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         s_done = grant_valid;
         tick();
         if (cyc % 2 == 0) begin
            total++; if (grant_valid !== 1'b1 || grant_num !== order[cyc/2])
               begin bad++; $display("FAIL rr_grant%0d: got gv=%0h num=%0h want gv=1 num=%0h", cyc/2, grant_valid, grant_num, order[cyc/2]); end
         end else begin
            total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL rr_gap%0d: got %0h want 0", cyc/2, grant_valid); end
         end
      end
      total++; if (outst !== 3'd0 || err !== 1'b0) begin bad++; $display("FAIL rr_end: got outst=%0h err=%0h want 0 0", outst, err); end
      m_req = '0; s_done = 1'b0;
   endtask

   task automatic test_owner_lock();
      do_reset();
      m_req = 4'b0010; s_aready = 1'b1;
      tick(); m_req = '0; tick();
      total++; if (outst !== 3'd1 || owner !== 2'd1) begin bad++; $display("FAIL lock_setup: got outst=%0h owner=%0h want 1 1", outst, owner); end
      m_req = 4'b0011;
      tick();
      total++; if (grant_valid !== 1'b1 || grant !== 4'b0010) begin bad++; $display("FAIL lock_owner_regrant: got gv=%0h grant=%0h want 1 2", grant_valid, grant); end
      m_req = '0;
      tick();
      total++; if (outst !== 3'd2) begin bad++; $display("FAIL lock_outst2: got %0h want 2", outst); end
      s_done = 1'b1; tick(); tick(); s_done = 1'b0;
      total++; if (outst !== 3'd0) begin bad++; $display("FAIL lock_clear: got %0h want 0", outst); end
      m_req = 4'b0011;
      tick();
      total++; if (grant_valid !== 1'b1 || grant_num !== 2'd0) begin bad++; $display("FAIL lock_release: got gv=%0h num=%0h want 1 0", grant_valid, grant_num); end
      m_req = '0; tick();
      s_done = 1'b1; tick(); s_done = 1'b0;
   endtask

   task automatic test_max_outst();
      do_reset();
      m_req = 4'b1000; s_aready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      total++; if (outst !== 3'd4 || owner !== 2'd3) begin bad++; $display("FAIL max_fill: got outst=%0h owner=%0h want 4 3", outst, owner); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL max_block%0d: got %0h want 0", i, grant_valid); end
      end
      s_done = 1'b1;
      tick();
      s_done = 1'b0;
      total++; if (outst !== 3'd3 || grant_valid !== 1'b0) begin bad++; $display("FAIL max_drop: got outst=%0h gv=%0h want 3 0", outst, grant_valid); end
      tick();
      total++; if (grant_valid !== 1'b1 || grant !== 4'b1000) begin bad++; $display("FAIL max_resume: got gv=%0h grant=%0h want 1 8", grant_valid, grant); end
      m_req = '0; tick();
      s_done = 1'b1; for (int i = 0; i < 4; i++) tick(); s_done = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      m_req = 4'b0100; s_aready = 1'b1;
      tick(); m_req = '0; tick();
      m_req = 4'b0100; s_aready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         m_req = 4'($urandom);
         tick();
         total++; if (grant_valid !== 1'b1 || grant !== 4'b0100) begin bad++; $display("FAIL stall%0d: got gv=%0h grant=%0h want 1 4", i, grant_valid, grant); end
      end
      m_req = '0; s_aready = 1'b1; s_done = 1'b1;
      tick();
      s_done = 1'b0;
      total++; if (outst !== 3'd1 || grant_valid !== 1'b0) begin bad++; $display("FAIL hs_done: got outst=%0h gv=%0h want 1 0", outst, grant_valid); end
      s_done = 1'b1; tick(); s_done = 1'b0;
   endtask

   task automatic test_err_reset();
      do_reset();
      s_done = 1'b1; tick(); s_done = 1'b0;
      total++; if (err !== 1'b1 || outst !== 3'd0) begin bad++; $display("FAIL err_set: got err=%0h outst=%0h want 1 0", err, outst); end
      m_req = 4'b0001; s_aready = 1'b0;
      tick(); tick();
      total++; if (grant_valid !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL err_hold: got gv=%0h err=%0h want 1 1", grant_valid, err); end
      reset = 1'b0;
      tick();
      total++; if (grant_valid !== 1'b0 || err !== 1'b0 || outst !== 3'd0) begin bad++; $display("FAIL mid_reset: got gv=%0h err=%0h outst=%0h want 0 0 0", grant_valid, err, outst); end
      reset = 1'b1; m_req = '0;
   endtask

   task automatic test_random();
      logic [3:0] eg;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         m_req    = 4'($urandom);
         s_aready = ($urandom_range(0, 3) != 0);
         s_done   = (md_outst > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 50) == 0);
         reset    = ($urandom_range(0, 150) != 0);
         tick();
         eg = (md_gv != 0) ? (4'b0001 << md_gidx) : 4'b0000;
         total++; if (grant_valid !== (md_gv != 0)) begin bad++; $display("FAIL rnd_gv@%0d: got %0h want %0h", cyc, grant_valid, md_gv); end
         total++; if (grant !== eg) begin bad++; $display("FAIL rnd_grant@%0d: got %0h want %0h", cyc, grant, eg); end
         total++; if (grant_num !== 2'(md_gidx)) begin bad++; $display("FAIL rnd_gnum@%0d: got %0h want %0h", cyc, grant_num, md_gidx); end
         total++; if (owner !== 2'(md_owner)) begin bad++; $display("FAIL rnd_owner@%0d: got %0h want %0h", cyc, owner, md_owner); end
         total++; if (outst !== 3'(md_outst)) begin bad++; $display("FAIL rnd_outst@%0d: got %0h want %0h", cyc, outst, md_outst); end
         total++; if (err !== (md_err != 0)) begin bad++; $display("FAIL rnd_err@%0d: got %0h want %0h", cyc, err, md_err); end
      end
      reset = 1'b1; m_req = '0; s_done = 1'b0;
   endtask

   initial begin
      reset = 1'b0; m_req = '0; s_aready = 1'b0; s_done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_owner_lock();
      test_max_outst();
      test_stall();
      test_err_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
